// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller with multi-cycle execute counter and deferred fetch redirect
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wait,
  input  logic             d_wait,
  input  logic             ex_multi,
  input  logic             ex_redirect,
  input  logic             de_is_load,
  input  logic [REG_W-1:0] de_rd,
  input  logic [REG_W-1:0] fd_rs1,
  input  logic [REG_W-1:0] fd_rs2,
  output logic [3:0]       enable,
  output logic [3:0]       flush,
  output logic             pc_en,
  output logic             pc_sel_redirect,
  output logic             redirect_pending
);
  localparam int CW = MUL_LAT > 2 ? $clog2(MUL_LAT) : 1;
  typedef enum logic {IDLE, MBUSY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d;
  logic load_use, mul_start, mul_stall, stall_m, stall_e, stall_d, redirect_take, pend_fire;
  always_comb begin
    load_use = de_is_load && de_rd != '0 && (de_rd == fd_rs1 || de_rd == fd_rs2);
    mul_start = state_q == IDLE && ex_multi && MUL_LAT > 1;
    mul_stall = state_q == IDLE ? mul_start : cnt_q != '0;
    stall_m = d_wait;
    stall_e = stall_m || mul_stall;
    stall_d = stall_e || load_use;
    redirect_take = ex_redirect && !stall_e;
    pend_fire = pend_q && !i_wait;
    state_d = state_q == IDLE ? (mul_start ? MBUSY : IDLE) : (cnt_q == '0 && !d_wait ? IDLE : MBUSY);
    cnt_d = mul_start ? CW'(MUL_LAT - 2) : (state_q == MBUSY && cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    pend_d = !pend_fire && (pend_q || (redirect_take && i_wait));
    enable = reset ? 4'b1111 : {1'b1, !stall_m, !stall_e, !stall_d};
    flush = reset ? 4'b1111 : {stall_m, stall_e && !stall_m, redirect_take || (load_use && !stall_e),
                               redirect_take || pend_fire || (!stall_d && i_wait)};
    pc_sel_redirect = !reset && ((redirect_take && !i_wait) || pend_fire);
    pc_en = !reset && (pc_sel_redirect || (!stall_d && !i_wait));
    redirect_pending = pend_q && !reset;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-step bench for hazard_ctrl with MUL_LAT=4
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset, i_wait, d_wait, ex_multi, ex_redirect, de_is_load;
  logic [4:0] de_rd, fd_rs1, fd_rs2;
  logic [3:0] enable, flush;
  logic pc_en, pc_sel_redirect, redirect_pending;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.MUL_LAT(4), .REG_W(5)) dut (
    .clk(clk), .reset(reset), .i_wait(i_wait), .d_wait(d_wait), .ex_multi(ex_multi),
    .ex_redirect(ex_redirect), .de_is_load(de_is_load), .de_rd(de_rd), .fd_rs1(fd_rs1),
    .fd_rs2(fd_rs2), .enable(enable), .flush(flush), .pc_en(pc_en),
    .pc_sel_redirect(pc_sel_redirect), .redirect_pending(redirect_pending)
  );
  task automatic cyc(input string tag, input logic [3:0] en, input logic [3:0] fl,
                     input logic pc, input logic sel, input logic pend);
    logic [10:0] obs, exp;
    @(negedge clk);
    obs = {enable, flush, pc_en, pc_sel_redirect, redirect_pending};
    exp = {en, fl, pc, sel, pend};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed en/fl/pc/sel/pend=%b expected=%b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    i_wait = 0; d_wait = 0; ex_multi = 0; ex_redirect = 0; de_is_load = 0;
    de_rd = 0; fd_rs1 = 0; fd_rs2 = 0;
  endtask
  initial begin
    idle_inputs();
    reset = 1;
    cyc("reset", 4'b1111, 4'b1111, 0, 0, 0);
    reset = 0;
    cyc("idle", 4'b1111, 4'b0000, 1, 0, 0);
    de_is_load = 1; de_rd = 5; fd_rs2 = 5;
    cyc("load_use_rs2", 4'b1110, 4'b0010, 0, 0, 0);
    de_rd = 0; fd_rs2 = 0;
    cyc("load_rd0", 4'b1111, 4'b0000, 1, 0, 0);
    de_rd = 5; fd_rs1 = 5; i_wait = 1;
    cyc("load_use_iwait", 4'b1110, 4'b0010, 0, 0, 0);
    idle_inputs(); i_wait = 1;
    cyc("iwait_only", 4'b1111, 4'b0001, 0, 0, 0);
    idle_inputs(); ex_multi = 1;
    cyc("mul1", 4'b1100, 4'b0100, 0, 0, 0);
    cyc("mul2", 4'b1100, 4'b0100, 0, 0, 0);
    cyc("mul3", 4'b1100, 4'b0100, 0, 0, 0);
    cyc("mul4_release", 4'b1111, 4'b0000, 1, 0, 0);
    cyc("b2b_mul1", 4'b1100, 4'b0100, 0, 0, 0);
    cyc("b2b_mul2", 4'b1100, 4'b0100, 0, 0, 0);
    d_wait = 1;
    cyc("mul_dwait3", 4'b1000, 4'b1000, 0, 0, 0);
    cyc("mul_dwait4", 4'b1000, 4'b1000, 0, 0, 0);
    cyc("mul_dwait5", 4'b1000, 4'b1000, 0, 0, 0);
    d_wait = 0;
    cyc("mul6_release", 4'b1111, 4'b0000, 1, 0, 0);
    ex_multi = 0;
    cyc("after_mul", 4'b1111, 4'b0000, 1, 0, 0);
    ex_redirect = 1;
    cyc("redirect", 4'b1111, 4'b0011, 1, 1, 0);
    de_is_load = 1; de_rd = 7; fd_rs1 = 7;
    cyc("redirect_over_lu", 4'b1110, 4'b0011, 1, 1, 0);
    idle_inputs(); ex_redirect = 1; d_wait = 1;
    cyc("redirect_frozen", 4'b1000, 4'b1000, 0, 0, 0);
    d_wait = 0; i_wait = 1;
    cyc("redirect_iwait", 4'b1111, 4'b0011, 0, 0, 0);
    ex_redirect = 0;
    cyc("pend1", 4'b1111, 4'b0001, 0, 0, 1);
    cyc("pend2", 4'b1111, 4'b0001, 0, 0, 1);
    cyc("pend3", 4'b1111, 4'b0001, 0, 0, 1);
    i_wait = 0;
    cyc("pend_fire", 4'b1111, 4'b0001, 1, 1, 1);
    cyc("pend_clear", 4'b1111, 4'b0000, 1, 0, 0);
    ex_redirect = 1; i_wait = 1;
    cyc("redirect_iwait2", 4'b1111, 4'b0011, 0, 0, 0);
    ex_redirect = 0; ex_multi = 1;
    cyc("mul_with_pend", 4'b1100, 4'b0100, 0, 0, 1);
    reset = 1;
    cyc("reset_mid", 4'b1111, 4'b1111, 0, 0, 0);
    reset = 0; idle_inputs();
    cyc("post_reset_idle", 4'b1111, 4'b0000, 1, 0, 0);
    cyc("post_reset_idle2", 4'b1111, 4'b0000, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central stall/flush controller for the 5-stage in-order pipeline (F, D, E, M, W). Every cycle it drives the `enable`/`flush` pair of the four pipeline registers (F/D, D/E, E/M, M/W) and the PC enable. Inputs are memory wait signals, load-use operands, branch redirects and multi-cycle execute ops. It owns two pieces of state: the multi-cycle execute counter, and the redirect that must wait for an outstanding instruction fetch.

## Interface
- MUL_LAT, 4: total cycles a multi-cycle op occupies E when unobstructed; legal values are ≥1.
- REG_W, 5: register-index width.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_wait  in  1  instruction fetch not yet returned.
- d_wait  in  1  data access in M not yet complete.
- ex_multi  in  1  E holds a multi-cycle op; stays high while that op is held in E.
- ex_redirect  in  1  E resolved a mispredict or jump; target is supplied to fetch externally.
- de_is_load  in  1  E holds a load (D/E register contents).
- de_rd  in  REG_W  destination register of the op in E.
- fd_rs1, fd_rs2  in  REG_W  sources of the op in D; bubbles carry 0.
- enable  out  4  per-register enable; bit 0 = F/D, 1 = D/E, 2 = E/M, 3 = M/W.
- flush  out  4  per-register flush (load zero); overrides enable.
- pc_en  out  1  PC register update.
- pc_sel_redirect  out  1  PC takes the redirect target this cycle.
- redirect_pending  out  1  a redirect is latched; fetch must hold its target.

## Operation
- Stall terms, all combinational:
  - load_use = de_is_load & de_rd≠0 & (de_rd==fd_rs1 | de_rd==fd_rs2)
  - stall_m = d_wait
  - stall_e = stall_m | mul_stall
  - stall_d = stall_e | load_use
- Register controls:
  - M/W: enable[3]=1, flush[3]=stall_m.
  - E/M: enable[2]=!stall_m, flush[2]=stall_e & !stall_m.
  - D/E: enable[1]=!stall_e, flush[1]=redirect_take | (load_use & !stall_e).
  - F/D: enable[0]=!stall_d, flush[0]=redirect_take | pend_fire | (!stall_d & i_wait).
- redirect_take = ex_redirect & !stall_e. A redirect is acted on only in the cycle E advances; while E is frozen, ex_redirect is held and ignored.
- Redirect handling:
  - redirect_take & !i_wait: pc_sel_redirect=1, pc_en=1.
  - redirect_take & i_wait: set redirect_pending; pc_en=0.
  - pend_fire = redirect_pending & !i_wait: pc_sel_redirect=1, pc_en=1, flush[0]=1 so the stale returned instruction is discarded. Fires regardless of stall_d. redirect_pending clears next cycle.
  - ex_redirect while pending: pending stays set; the target update is external.
- Otherwise pc_en = !stall_d & !i_wait.
- Multi-cycle FSM, states IDLE and MBUSY, with counter cnt of $clog2(MUL_LAT) bits (minimum 1):
  - IDLE & ex_multi & MUL_LAT>1: mul_stall=1, cnt←MUL_LAT-2, go to MBUSY.
  - IDLE with MUL_LAT==1: mul_stall is never asserted.
  - MBUSY: mul_stall = (cnt≠0). cnt decrements while nonzero, independent of d_wait.
  - MBUSY exits to IDLE when cnt==0 & !d_wait, i.e. in the cycle E advances.
  - A back-to-back multi op is detected by IDLE on the following cycle.
- reset: FSM goes to IDLE, cnt=0, redirect_pending=0. During reset: flush=4'b1111, enable=4'b1111, pc_en=0, pc_sel_redirect=0.

## Timing
- All outputs are combinational from inputs and state; there is zero-cycle latency from stall input to enable/flush.
- The state (FSM, cnt, redirect_pending) updates on the rising clk edge.
- Multi op, no d_wait: E is stalled for exactly MUL_LAT-1 cycles; E/M captures the op at the end of cycle MUL_LAT.
- Pending redirect: pc_sel_redirect is asserted in the first cycle with i_wait=0, and in no other cycle.
- Simultaneous events:
  - d_wait dominates every other stall.
  - A redirect overrides load_use, because D is flushed.
  - When i_wait and load_use coincide, load_use wins: F/D holds, it is not flushed.
- Reset asserted mid-multi-op or mid-pending: state clears in that cycle; the pending redirect is dropped.

## Test plan
- Load-use: de_is_load=1, de_rd=5, fd_rs2=5, one cycle → enable=4'b1110, flush=4'b0010, pc_en=0. With de_rd=0 → no stall.
- Multi op, MUL_LAT=4: ex_multi held for 4 cycles → mul_stall for 3 cycles, flush[2]=1 in each of them. Cycle 4: enable=4'b1111, FSM returns to IDLE.
- Multi op with d_wait=1 on cycles 3–5 → cnt holds 0. E is released only in cycle 6; the M/W flush is set in cycles 3–5.
- Redirect with i_wait=0 → flush=4'b0011, pc_en=1, pc_sel_redirect=1 in the same cycle.
- Redirect with i_wait=1 for 3 further cycles → redirect_pending=1 for those cycles. In the first i_wait=0 cycle: pc_sel_redirect=1, flush[0]=1; next cycle redirect_pending=0.
- Reset during MBUSY with a redirect pending → the next cycle shows IDLE, redirect_pending=0, and no stalls with idle inputs.
